// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared mode encodings and helpers for the dec_scan decoder
package dec_pkg;

  localparam logic DEC_MODE_DIRECT = 1'b0;
  localparam logic DEC_MODE_SCAN   = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Sized for the widest legal select (N=6); callers keep the low 2^N bits.
  function automatic logic [63:0] onehot(input logic [5:0] sel);
    return 64'd1 << sel;
  endfunction

endpackage

// File: rtl/dec_dwell_timer.sv
// rtl/dec_dwell_timer.sv - dwell counter for scan mode, ticks on the last cycle of each line
module dec_dwell_timer
  import dec_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/dec_scan.sv
// rtl/dec_scan.sv - registered N-to-2^N one-hot decoder with scan sequencer
// Optional blank cycle between scan lines: define DEC_SCAN_BLANK_EN.
module dec_scan
  import dec_pkg::*;
#(
  parameter int N   = 2,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           mode,
  input  logic [N-1:0]   a,
  output logic [2**N-1:0] s,
  output logic [N-1:0]   idx,
  output logic           wrap
);

  localparam int W = 2**N;
  localparam logic [N-1:0] IDX_MAX = '1;

  logic           scan_q;
  logic           scanning;
  logic           run;
  logic           tick;
  logic [W-1:0]   s_n;
  logic [N-1:0]   idx_n;
  logic [N-1:0]   idx_inc;
  logic           wrap_n;

  function automatic logic [W-1:0] dec(input logic [N-1:0] v);
    logic [5:0]  sel;
    logic [63:0] full;
    sel        = '0;
    sel[N-1:0] = v;
    full       = onehot(sel);
    return full[W-1:0];
  endfunction

  assign scanning = en && (mode == DEC_MODE_SCAN);

`ifdef DEC_SCAN_BLANK_EN
  logic blank;
  logic blank_n;
  assign run = scanning && scan_q && !blank;
`else
  assign run = scanning && scan_q;
`endif

  // Anything that is not steady scanning (disable, direct, entry, blank) parks the counter at 0.
  dec_dwell_timer #(.DIV(DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clr   (!run),
    .tick  (tick)
  );

  always_comb begin
    s_n     = s;
    idx_n   = idx;
    wrap_n  = 1'b0;
    idx_inc = idx + 1'b1;
`ifdef DEC_SCAN_BLANK_EN
    blank_n = 1'b0;
`endif
    if (!en) begin
      s_n = '0;
    end else if (mode == DEC_MODE_DIRECT) begin
      idx_n = a;
      s_n   = dec(a);
    end else if (!scan_q) begin
      idx_n = '0;
      s_n   = dec('0);
`ifdef DEC_SCAN_BLANK_EN
    end else if (blank) begin
      s_n = dec(idx);
    end else if (tick) begin
      idx_n   = idx_inc;
      wrap_n  = (idx == IDX_MAX);
      s_n     = '0;
      blank_n = 1'b1;
`else
    end else if (tick) begin
      idx_n  = idx_inc;
      wrap_n = (idx == IDX_MAX);
      s_n    = dec(idx_inc);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s      <= '0;
      idx    <= '0;
      wrap   <= 1'b0;
      scan_q <= 1'b0;
    end else begin
      s      <= s_n;
      idx    <= idx_n;
      wrap   <= wrap_n;
      scan_q <= scanning;
    end
  end

`ifdef DEC_SCAN_BLANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank <= 1'b0;
    else        blank <= blank_n;
  end
`endif

endmodule

// File: tb/tb_dec_scan.sv
// tb/tb_dec_scan.sv - scoreboard bench for dec_scan (N=2/DIV=3 main, N=3/DIV=2 direct)
module tb_dec_scan;

  typedef struct {
    logic [3:0] s;
    logic [1:0] idx;
    logic       wrap;
    bit         chk3;
    logic [7:0] s3;
    logic [2:0] idx3;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       mode  = 1'b0;
  logic [1:0] a     = '0;
  logic [2:0] a3    = '0;
  logic [3:0] s;
  logic [1:0] idx;
  logic       wrap;
  logic [7:0] s3;
  logic [2:0] idx3;
  logic       wrap3;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t plan[$];
  bit   wrap_next = 1'b0;

  dec_scan #(.N(2), .DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
    .s(s), .idx(idx), .wrap(wrap)
  );

  dec_scan #(.N(3), .DIV(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a3),
    .s(s3), .idx(idx3), .wrap(wrap3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] sv, input logic [1:0] iv, input logic wv);
    exp_t x;
    x.s    = sv;
    x.idx  = iv;
    x.wrap = wv;
    x.chk3 = 1'b0;
    x.s3   = '0;
    x.idx3 = '0;
    return x;
  endfunction

  task automatic cyc(input string tag, input logic e, input logic m,
                     input logic [1:0] av, input logic [2:0] a3v, input exp_t x);
    exp_t g;
    @(negedge clk);
    en   = e;
    mode = m;
    a    = av;
    a3   = a3v;
    sb.push_back(x);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({tag, ".s"}, 32'(s), 32'(g.s));
    check({tag, ".idx"}, 32'(idx), 32'(g.idx));
    check({tag, ".wrap"}, 32'(wrap), 32'(g.wrap));
    if (g.chk3) begin
      check({tag, ".s3"}, 32'(s3), 32'(g.s3));
      check({tag, ".idx3"}, 32'(idx3), 32'(g.idx3));
      check({tag, ".wrap3"}, 32'(wrap3), 32'd0);
    end
  endtask

  task automatic plan_line(input int line, input int reps);
    for (int r = 0; r < reps; r++) begin
      plan.push_back(mk(4'b0001 << line, 2'(line), wrap_next && (r == 0)));
    end
    wrap_next = 1'b0;
  endtask

  task automatic plan_advance(input int next);
`ifdef DEC_SCAN_BLANK_EN
    plan.push_back(mk(4'b0000, 2'(next), next == 0));
`else
    wrap_next = (next == 0);
`endif
  endtask

  task automatic run_plan(input string tag);
    while (plan.size() > 0) begin
      cyc(tag, 1'b1, 1'b1, 2'd0, 3'd0, plan.pop_front());
    end
  endtask

  initial begin
    exp_t x;

    repeat (2) @(posedge clk);
    #1;
    check("rst.s", 32'(s), 32'd0);
    check("rst.idx", 32'(idx), 32'd0);
    check("rst.wrap", 32'(wrap), 32'd0);
    check("rst.s3", 32'(s3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      x      = mk(4'b0001 << i, 2'(i), 1'b0);
      x.chk3 = 1'b1;
      x.s3   = 8'b0000_0001 << (7 - i);
      x.idx3 = 3'(7 - i);
      cyc("direct", 1'b1, 1'b0, 2'(i), 3'(7 - i), x);
    end

    cyc("gate_on", 1'b1, 1'b0, 2'd2, 3'd0, mk(4'b0100, 2'd2, 1'b0));
    cyc("gate_off", 1'b0, 1'b0, 2'd2, 3'd0, mk(4'b0000, 2'd2, 1'b0));
    cyc("gate_back", 1'b1, 1'b0, 2'd2, 3'd0, mk(4'b0100, 2'd2, 1'b0));

    wrap_next = 1'b0;
    plan_line(0, 3);
    for (int p = 0; p < 2; p++) begin
      for (int l = 1; l < 4; l++) begin
        plan_advance(l);
        plan_line(l, 3);
      end
      plan_advance(0);
      plan_line(0, (p == 1) ? 1 : 3);
    end
    run_plan("scan");

    plan_line(0, 2);
    plan_advance(1);
    plan_line(1, 3);
    plan_advance(2);
    plan_line(2, 1);
    run_plan("scan_to2");

    cyc("msw_direct", 1'b1, 1'b0, 2'd3, 3'd0, mk(4'b1000, 2'd3, 1'b0));
    cyc("msw_scan", 1'b1, 1'b1, 2'd0, 3'd0, mk(4'b0001, 2'd0, 1'b0));

    plan_line(0, 2);
    plan_advance(1);
    plan_line(1, 2);
    run_plan("scan_re");

    #2;
    rst_n = 1'b0;
    #1;
    check("arst.s", 32'(s), 32'd0);
    check("arst.idx", 32'(idx), 32'd0);
    check("arst.wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc("post_rst", 1'b1, 1'b0, 2'd1, 3'd0, mk(4'b0010, 2'd1, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
